// File: rtl/uart_tx_engine.sv
// ============================================================================
// Module   : uart_tx_engine
// Purpose  : 16550-style transmit engine: holding + shift register, framing FSM
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_engine #(
  parameter int OVERSAMPLE = 16
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic [15:0] DIVISOR_I,
  input  logic [7:0]  LCR_I,
  input  logic [7:0]  TX_DATA_I,
  input  logic        TX_VALID_I,
  output logic        TX_READY_O,
  output logic        TXD_O,
  output logic        THRE_O,
  output logic        TEMT_O
);

  localparam int c_OS_W = $clog2(OVERSAMPLE + 1);
  localparam logic [c_OS_W-1:0] c_OS_LAST = c_OS_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t            r_state,      w_state;
  logic [7:0]        r_hold_data,  w_hold_data;
  logic              r_hold_empty, w_hold_empty;
  logic [7:0]        r_shift,      w_shift;
  logic [3:0]        r_lcr,        w_lcr;
  logic [15:0]       r_div,        w_div;
  logic [15:0]       r_baud_cnt,   w_baud_cnt;
  logic [c_OS_W-1:0] r_os_cnt,     w_os_cnt;
  logic [2:0]        r_bit_cnt,    w_bit_cnt;
  logic              r_parity,     w_parity;
  logic              r_line,       w_line;
  logic              r_txd,        w_txd;
  logic              r_temt,       w_temt;

  logic       w_tick, w_bit_end, w_accept, w_load, w_load_par;
  logic [7:0] w_mask;
  logic       w_unused;

  assign w_unused = LCR_I[7];

  // Parity is resolved at load time from the LCR value latched for the frame
  assign w_mask     = 8'hFF >> (2'd3 - LCR_I[1:0]);
  assign w_load_par = LCR_I[5] ? ~LCR_I[4] : ((^(r_hold_data & w_mask)) ^ ~LCR_I[4]);

  assign w_tick    = (r_baud_cnt == r_div);
  assign w_bit_end = w_tick && (r_os_cnt == c_OS_LAST);
  assign w_accept  = TX_VALID_I && r_hold_empty;

  always_comb begin
    w_state      = r_state;
    w_hold_data  = r_hold_data;
    w_hold_empty = r_hold_empty;
    w_shift      = r_shift;
    w_lcr        = r_lcr;
    w_div        = r_div;
    w_baud_cnt   = r_baud_cnt;
    w_os_cnt     = r_os_cnt;
    w_bit_cnt    = r_bit_cnt;
    w_parity     = r_parity;
    w_line       = r_line;
    w_load       = 1'b0;

    if (r_state != S_IDLE) begin
      if (w_tick) begin
        w_baud_cnt = 16'd0;
        w_os_cnt   = (r_os_cnt == c_OS_LAST) ? '0 : r_os_cnt + 1'b1;
      end else begin
        w_baud_cnt = r_baud_cnt + 16'd1;
      end
    end

    case (r_state)
      S_IDLE: begin
        w_line = 1'b1;
        if (!r_hold_empty) w_load = 1'b1;
      end
      S_START: begin
        if (w_bit_end) begin
          w_state   = S_DATA;
          w_line    = r_shift[0];
          w_bit_cnt = 3'd0;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          if (r_bit_cnt == (3'd4 + {1'b0, r_lcr[1:0]})) begin
            w_bit_cnt = 3'd0;
            if (r_lcr[3]) begin
              w_state = S_PARITY;
              w_line  = r_parity;
            end else begin
              w_state = S_STOP;
              w_line  = 1'b1;
            end
          end else begin
            w_bit_cnt = r_bit_cnt + 3'd1;
            w_shift   = r_shift >> 1;
            w_line    = r_shift[1];
          end
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_state   = S_STOP;
          w_line    = 1'b1;
          w_bit_cnt = 3'd0;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          if (r_lcr[2] && (r_bit_cnt == 3'd0)) begin
            w_bit_cnt = 3'd1;
          end else if (!r_hold_empty) begin
            w_load = 1'b1;
          end else begin
            w_state = S_IDLE;
            w_line  = 1'b1;
          end
        end
      end
      default: begin
        w_state = S_IDLE;
        w_line  = 1'b1;
      end
    endcase

    // A load starts a fresh frame, so it takes priority over the state's own update
    if (w_load) begin
      w_state      = S_START;
      w_shift      = r_hold_data;
      w_lcr        = LCR_I[3:0];
      w_div        = DIVISOR_I;
      w_hold_empty = 1'b1;
      w_baud_cnt   = 16'd0;
      w_os_cnt     = '0;
      w_bit_cnt    = 3'd0;
      w_parity     = w_load_par;
      w_line       = 1'b0;
    end

    if (w_accept) begin
      w_hold_data  = TX_DATA_I;
      w_hold_empty = 1'b0;
    end

    w_txd  = w_line & ~LCR_I[6];
    w_temt = (w_state == S_IDLE) && w_hold_empty;
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_state      <= S_IDLE;
      r_hold_data  <= 8'd0;
      r_hold_empty <= 1'b1;
      r_shift      <= 8'd0;
      r_lcr        <= 4'd0;
      r_div        <= 16'd0;
      r_baud_cnt   <= 16'd0;
      r_os_cnt     <= '0;
      r_bit_cnt    <= 3'd0;
      r_parity     <= 1'b0;
      r_line       <= 1'b1;
      r_txd        <= 1'b1;
      r_temt       <= 1'b1;
    end else begin
      r_state      <= w_state;
      r_hold_data  <= w_hold_data;
      r_hold_empty <= w_hold_empty;
      r_shift      <= w_shift;
      r_lcr        <= w_lcr;
      r_div        <= w_div;
      r_baud_cnt   <= w_baud_cnt;
      r_os_cnt     <= w_os_cnt;
      r_bit_cnt    <= w_bit_cnt;
      r_parity     <= w_parity;
      r_line       <= w_line;
      r_txd        <= w_txd;
      r_temt       <= w_temt;
    end
  end

  assign TX_READY_O = r_hold_empty;
  assign THRE_O     = r_hold_empty;
  assign TXD_O      = r_txd;
  assign TEMT_O     = r_temt;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_engine.sv
// ============================================================================
// Module   : tb_uart_tx_engine
// Purpose  : directed self-checking bench for uart_tx_engine
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] divisor = 16'd0;
  logic [7:0]  lcr = 8'h03;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_valid = 1'b0;
  logic        tx_ready, txd, thre, temt;

  int n_vec = 0;
  int n_err = 0;

  uart_tx_engine #(.OVERSAMPLE(16)) dut (
    .CLK_I      (clk),
    .RST_I      (rst_n),
    .DIVISOR_I  (divisor),
    .LCR_I      (lcr),
    .TX_DATA_I  (tx_data),
    .TX_VALID_I (tx_valid),
    .TX_READY_O (tx_ready),
    .TXD_O      (txd),
    .THRE_O     (thre),
    .TEMT_O     (temt)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d);
    tx_valid = 1'b1;
    tx_data  = d;
    @(posedge clk);
    #1 tx_valid = 1'b0;
  endtask

  // Starts at the negedge of the first START cell; every sample of each bit
  // cell must match, break window [bf,bt) drives LCR[6] and shows one cycle later.
  task automatic run_frame(input string tag, input logic [15:0] bits, input int nbits,
                           input int cpb, input int bf, input int bt);
    int   good;
    int   j;
    logic e;
    for (int b = 0; b < nbits; b++) begin
      good = 0;
      for (int c = 0; c < cpb; c++) begin
        j = b * cpb + c;
        e = ((j - 1) >= bf && (j - 1) < bt) ? 1'b0 : bits[b];
        if (txd === e) good++;
        if (j == nbits * cpb - 1) check_vec({tag, " busy_end"}, temt, 1'b0);
        lcr[6] = (j >= bf && j < bt);
        @(negedge clk);
      end
      check_vec($sformatf("%s bit%0d", tag, b), good, cpb);
    end
    lcr[6] = 1'b0;
  endtask

  initial begin
    int zeros;
    #2 rst_n = 1'b0;
    #1;
    check_vec("rst txd",   txd,      1'b1);
    check_vec("rst ready", tx_ready, 1'b1);
    check_vec("rst thre",  thre,     1'b1);
    check_vec("rst temt",  temt,     1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 8N1, divisor 0, 0x55
    divisor = 16'd0; lcr = 8'h03;
    send_byte(8'h55);
    @(negedge clk);
    check_vec("accept temt",  temt,     1'b0);
    check_vec("accept txd",   txd,      1'b1);
    check_vec("accept ready", tx_ready, 1'b0);
    @(negedge clk);
    check_vec("load txd",   txd,      1'b0);
    check_vec("load ready", tx_ready, 1'b1);
    run_frame("f55", 16'h02AA, 10, 16, -1, -1);
    check_vec("f55 idle txd",  txd,  1'b1);
    check_vec("f55 idle temt", temt, 1'b1);

    // 8E1, divisor 1, 0x01 -> parity 1
    divisor = 16'd1; lcr = 8'h1B;
    send_byte(8'h01);
    @(negedge clk); @(negedge clk);
    run_frame("f8e1", 16'h0602, 11, 32, -1, -1);
    check_vec("f8e1 idle temt", temt, 1'b1);

    // 5N1 back-to-back 0xFF, 0x00; byte offered while busy must be ignored
    divisor = 16'd0; lcr = 8'h00;
    send_byte(8'hFF);
    @(negedge clk); @(negedge clk);
    check_vec("b2b ready1", tx_ready, 1'b1);
    fork
      send_byte(8'h00);
      begin
        repeat (50) @(negedge clk);
        check_vec("b2b busy ready", tx_ready, 1'b0);
        tx_valid = 1'b1; tx_data = 8'hC3;
        @(negedge clk);
        tx_valid = 1'b0;
      end
    join_none
    run_frame("b2b_ff", 16'h007E, 7, 16, -1, -1);
    check_vec("b2b ready2", tx_ready, 1'b1);
    run_frame("b2b_00", 16'h0040, 7, 16, -1, -1);
    zeros = 0;
    for (int i = 0; i < 40; i++) begin
      if (txd !== 1'b1) zeros++;
      @(negedge clk);
    end
    check_vec("b2b no third", zeros, 0);
    check_vec("b2b temt", temt, 1'b1);

    // 8N2 0xA5 with break asserted during data
    lcr = 8'h07;
    send_byte(8'hA5);
    @(negedge clk); @(negedge clk);
    run_frame("brk", 16'h074A, 11, 16, 40, 80);
    check_vec("brk end temt", temt, 1'b1);

    // divisor and LCR change mid-frame only affect the next frame
    divisor = 16'd0; lcr = 8'h03;
    send_byte(8'h55);
    @(negedge clk); @(negedge clk);
    fork
      begin
        repeat (20) @(negedge clk);
        divisor = 16'd3; lcr = 8'h0B;
        send_byte(8'h0F);
      end
    join_none
    run_frame("div_a", 16'h02AA, 10, 16, -1, -1);
    run_frame("div_b", 16'h061E, 11, 64, -1, -1);
    check_vec("div idle temt", temt, 1'b1);

    // asynchronous reset during data with holding full
    divisor = 16'd0; lcr = 8'h03;
    send_byte(8'h11);
    @(negedge clk); @(negedge clk);
    send_byte(8'h22);
    repeat (30) @(negedge clk);
    check_vec("pre rst ready", tx_ready, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_vec("arst txd",   txd,      1'b1);
    check_vec("arst ready", tx_ready, 1'b1);
    check_vec("arst temt",  temt,     1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    zeros = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) zeros++;
    end
    check_vec("post rst quiet", zeros, 0);
    check_vec("post rst temt", temt, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_tx_engine.md
UART_TX_ENGINE -- requirements
Module: uart_tx_engine

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16, meaning baud ticks per serial bit.
REQ-002 SHALL have port CLK_I  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port RST_I  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port DIVISOR_I  input  16  baud divisor; one baud tick every DIVISOR_I+1 clocks.
REQ-005 SHALL have port LCR_I  input  8  line control: [1:0] word length 5..8, [2] stop bits (0=1, 1=2), [3] parity enable, [4] even parity, [5] stick parity, [6] break.
REQ-006 SHALL have port TX_DATA_I  input  8  byte from transmit FIFO.
REQ-007 SHALL have port TX_VALID_I  input  1  TX_DATA_I valid.
REQ-008 SHALL have port TX_READY_O  output  1  holding register empty; byte accepted when VALID and READY both high at a rising edge.
REQ-009 SHALL have port TXD_O  output  1  serial line, idle high.
REQ-010 SHALL have port THRE_O  output  1  holding register empty (LSR bit 5).
REQ-011 SHALL have port TEMT_O  output  1  holding and shift register both empty, line idle (LSR bit 6).

Function
REQ-012 SHALL hold one byte in a holding register plus one in a shift register; TX_READY_O = THRE_O = holding empty.
REQ-013 SHALL implement states IDLE, START, DATA, PARITY, STOP; all outputs registered.
REQ-014 IDLE: TXD_O=1; if holding full, SHALL load shift register, latch LCR_I[5:0] and DIVISOR_I, clear holding, reset baud and bit counters, enter START on that same edge.
REQ-015 Byte accepted at edge k while IDLE with holding empty -> load at edge k+1, TXD_O=0 and TX_READY_O=1 after edge k+1.
REQ-016 Each state SHALL last exactly OVERSAMPLE baud ticks, i.e. OVERSAMPLE*(latched DIVISOR+1) clocks per bit.
REQ-017 START drives 0; then DATA drives shift bits LSB first, count 5+LCR[1:0]; bits above word length ignored.
REQ-018 PARITY entered only if LCR[3]=1; value = XOR of sent data bits, inverted when LCR[4]=0 (odd); when LCR[5]=1, value = ~LCR[4] (stick).
REQ-019 STOP drives 1 for 1 bit (LCR[2]=0) or 2 bits (LCR[2]=1); 5-bit word with LCR[2]=1 uses 2 bits (no 1.5).
REQ-020 At end of STOP: holding full -> load and enter START on same edge (back-to-back, no idle bit); else IDLE.
REQ-021 Holding may be refilled any time it is empty, including during DATA/STOP of current frame.
REQ-022 TEMT_O=1 only in IDLE with holding empty; it SHALL drop on the edge that accepts a byte.
REQ-023 LCR_I[6]=1 SHALL force TXD_O=0 next cycle regardless of state; framing counters continue unaffected; release restores FSM-driven value next cycle.
REQ-024 Changes to LCR_I[5:0] or DIVISOR_I mid-frame SHALL not affect the frame in progress.
REQ-025 Baud counter SHALL wrap at latched divisor; divisor 0 yields a tick every clock.
REQ-026 TX_VALID_I with TX_READY_O=0 SHALL be ignored; data not consumed.

Reset
REQ-027 RST_I low SHALL immediately, without a clock, force: state IDLE, TXD_O=1, TX_READY_O=1, THRE_O=1, TEMT_O=1, holding and shift empty, all counters 0.
REQ-028 Reset mid-frame SHALL abort the frame; any held byte is discarded; line returns high.
REQ-029 After RST_I rises, first accept SHALL be possible on the next rising edge.

Verification
REQ-030 DIVISOR_I=0, LCR_I=0x03, send 0x55 -> TXD_O: 0 for 16 clk, then 1,0,1,0,1,0,1,0 each 16 clk, then 1; 160 clk frame; TEMT_O=1 after.
REQ-031 LCR_I=0x1B (8E1), DIVISOR_I=1, send 0x01 -> parity bit 1, each bit 32 clk, frame 11 bits = 352 clk.
REQ-032 LCR_I=0x00 (5N1), send 0xFF then 0x00 back-to-back -> frames 7 bits each, second START immediately follows first STOP, TX_READY_O high during first frame after load.
REQ-033 LCR_I=0x07 (8N2) send 0xA5, assert LCR_I[6] during DATA for 40 clk -> TXD_O=0 throughout, frame end timing unchanged (176 clk).
REQ-034 Assert RST_I low during DATA with holding full -> TXD_O=1, TX_READY_O=1, TEMT_O=1 asynchronously; no further frame after release.
REQ-035 Change DIVISOR_I 0->3 mid-frame -> current frame keeps 16 clk/bit, next frame 64 clk/bit.
